// File: rtl/sram_1rw_arbiter_ctrl.sv
// Two-port round-robin controller for a 1RW SRAM macro: clears the array after reset, 2-cycle reads.
// Optional SRAM_ARB_PARITY_EN: even parity in bit DATA_WIDTH, partial writes done as read-modify-write.
module sram_1rw_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int INIT_DEPTH = 512
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [NUM_WMASKS-1:0] p0_req_wmask,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [NUM_WMASKS-1:0] p1_req_wmask,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_perr,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_perr,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH:0]   sram_din0,
  input  logic [DATA_WIDTH:0]   sram_dout0
);

  localparam int BW = DATA_WIDTH / NUM_WMASKS;

  typedef enum logic [2:0] {INIT, RUN, RMW_RD, RMW_WAIT, RMW_WR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ptr;
  logic                  gnt0, gnt1;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  cmd_csb, cmd_web, cmd_spare, rd_issue, rd_perr;
  logic [NUM_WMASKS-1:0] cmd_wmask;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH:0]   cmd_din;
  logic                  tok_a_vld, tok_a_port, tok_b_vld, tok_b_port;

  // ptr=0 favours p0 when both ports ask in the same cycle
  assign gnt0 = (state == RUN) && p0_req_valid && (!p1_req_valid || !ptr);
  assign gnt1 = (state == RUN) && p1_req_valid && !gnt0;
  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  assign sel_we    = gnt1 ? p1_req_we    : p0_req_we;
  assign sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
  assign sel_wmask = gnt1 ? p1_req_wmask : p0_req_wmask;
  assign sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;

`ifdef SRAM_ARB_PARITY_EN
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [NUM_WMASKS-1:0] rmw_wmask;
  logic [DATA_WIDTH-1:0] rmw_wdata, rmw_rdata, merged;
  logic                  rmw_wait;

  // stored bit DATA_WIDTH is even parity, so a clean word xors to zero
  assign rd_perr = ^sram_dout0;
`else
  logic unused_dout_spare;
  assign unused_dout_spare = sram_dout0[DATA_WIDTH];
  assign rd_perr = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cmd_csb   = 1'b1;
    cmd_web   = 1'b1;
    cmd_wmask = '0;
    cmd_spare = 1'b0;
    cmd_addr  = '0;
    cmd_din   = '0;
    rd_issue  = 1'b0;
`ifdef SRAM_ARB_PARITY_EN
    merged = '0;
    for (int i = 0; i < NUM_WMASKS; i++)
      merged[i*BW +: BW] = rmw_wmask[i] ? rmw_wdata[i*BW +: BW] : rmw_rdata[i*BW +: BW];
`endif
    case (state)
      INIT: begin
        cmd_csb   = 1'b0;
        cmd_web   = 1'b0;
        cmd_wmask = '1;
        cmd_spare = 1'b1;
        cmd_addr  = cnt;
        if (cnt == ADDR_WIDTH'(INIT_DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (gnt0 || gnt1) begin
          cmd_csb  = 1'b0;
          cmd_addr = sel_addr;
          if (sel_we) begin
`ifdef SRAM_ARB_PARITY_EN
            if (&sel_wmask) begin
              cmd_web   = 1'b0;
              cmd_wmask = '1;
              cmd_spare = 1'b1;
              cmd_din   = {^sel_wdata, sel_wdata};
            end else begin
              state_nxt = RMW_RD;  // command stays a read of the old word
            end
`else
            cmd_web   = 1'b0;
            cmd_wmask = sel_wmask;
            cmd_din   = {1'b0, sel_wdata};
`endif
          end else begin
            rd_issue = 1'b1;
          end
        end
      end
`ifdef SRAM_ARB_PARITY_EN
      RMW_RD:   state_nxt = RMW_WAIT;
      RMW_WAIT: if (rmw_wait) state_nxt = RMW_WR;
      RMW_WR: begin
        cmd_csb   = 1'b0;
        cmd_web   = 1'b0;
        cmd_wmask = '1;
        cmd_spare = 1'b1;
        cmd_addr  = rmw_addr;
        cmd_din   = {^merged, merged};
        state_nxt = RUN;
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) state <= INIT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      sram_csb0       <= 1'b1;
      sram_web0       <= 1'b1;
      sram_wmask0     <= '0;
      sram_spare_wen0 <= 1'b0;
      sram_addr0      <= '0;
      sram_din0       <= '0;
      cnt             <= '0;
      ptr             <= 1'b0;
      init_done       <= 1'b0;
      tok_a_vld       <= 1'b0;
      tok_a_port      <= 1'b0;
      tok_b_vld       <= 1'b0;
      tok_b_port      <= 1'b0;
      p0_rsp_valid    <= 1'b0;
      p1_rsp_valid    <= 1'b0;
      p0_rsp_rdata    <= '0;
      p1_rsp_rdata    <= '0;
      p0_rsp_perr     <= 1'b0;
      p1_rsp_perr     <= 1'b0;
    end else begin
      sram_csb0       <= cmd_csb;
      sram_web0       <= cmd_web;
      sram_wmask0     <= cmd_wmask;
      sram_spare_wen0 <= cmd_spare;
      sram_addr0      <= cmd_addr;
      sram_din0       <= cmd_din;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (state == INIT && state_nxt == RUN) init_done <= 1'b1;
      if (p0_req_valid && p1_req_valid && (gnt0 || gnt1)) ptr <= gnt0;
      // token stage a: command on pins, stage b: macro has captured it
      tok_a_vld    <= rd_issue;
      tok_a_port   <= gnt1;
      tok_b_vld    <= tok_a_vld;
      tok_b_port   <= tok_a_port;
      p0_rsp_valid <= tok_b_vld && !tok_b_port;
      p1_rsp_valid <= tok_b_vld && tok_b_port;
      if (tok_b_vld && !tok_b_port) begin
        p0_rsp_rdata <= sram_dout0[DATA_WIDTH-1:0];
        p0_rsp_perr  <= rd_perr;
      end
      if (tok_b_vld && tok_b_port) begin
        p1_rsp_rdata <= sram_dout0[DATA_WIDTH-1:0];
        p1_rsp_perr  <= rd_perr;
      end
    end
  end

`ifdef SRAM_ARB_PARITY_EN
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rmw_addr  <= '0;
      rmw_wmask <= '0;
      rmw_wdata <= '0;
      rmw_rdata <= '0;
      rmw_wait  <= 1'b0;
    end else begin
      if (state == RUN && state_nxt == RMW_RD) begin
        rmw_addr  <= sel_addr;
        rmw_wmask <= sel_wmask;
        rmw_wdata <= sel_wdata;
      end
      if (state == RMW_WAIT) begin
        rmw_wait <= ~rmw_wait;
        if (!rmw_wait) rmw_rdata <= sram_dout0[DATA_WIDTH-1:0];
      end
    end
  end
`endif

endmodule

// File: doc/sram_1rw_arbiter_ctrl.md
Name: sram_1rw_arbiter_ctrl

Overview:
- Two-requester controller in front of one 1RW OpenRAM macro with a 32-bit data path, 4 byte masks and a spare bit 32.
- Round-robin arbitration between requesters.
- Registers the command onto the macro pins and captures read data at the correct edge.
- Routes each response back to the requester that issued it.
- Clears the whole array to zero after reset, before any requester traffic is accepted.

Parameters:
- ADDR_WIDTH, 10, macro address width.
- DATA_WIDTH, 32, requester data width; macro width is DATA_WIDTH+1.
- NUM_WMASKS, 4, byte write-mask width.
- INIT_DEPTH, 512, number of words cleared after reset, at addresses 0..INIT_DEPTH-1.

Ports:
- clk0  in  1  clock; all logic on posedge.
- rst0  in  1  synchronous, active-high reset.
- p0_req_valid, p1_req_valid  in  1  request valid.
- p0_req_ready, p1_req_ready  out  1  request accepted this cycle.
- p0_req_we, p1_req_we  in  1  1 = write, 0 = read.
- p0_req_addr, p1_req_addr  in  ADDR_WIDTH  word address.
- p0_req_wmask, p1_req_wmask  in  NUM_WMASKS  byte enables.
- p0_req_wdata, p1_req_wdata  in  DATA_WIDTH  write data.
- p0_rsp_valid, p1_rsp_valid  out  1  one-cycle read data strobe.
- p0_rsp_rdata, p1_rsp_rdata  out  DATA_WIDTH  read data.
- p0_rsp_perr, p1_rsp_perr  out  1  parity error; qualified by rsp_valid.
- init_done  out  1  high once the clear sequence completes.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro byte mask.
- sram_spare_wen0  out  1  macro spare-bit write enable.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH+1  macro write data.
- sram_dout0  in  DATA_WIDTH+1  macro read data.

Behaviour:
- Clock and reset: one clock, clk0. Reset rst0 is synchronous and active-high.
- Reset values:
  - sram_csb0=1, sram_web0=1; sram_wmask0, sram_spare_wen0, sram_addr0, sram_din0 all 0.
  - All req_ready and rsp_valid = 0; init_done = 0; round-robin pointer = p0.
  - In-flight read tokens are flushed.
  - State = INIT with the clear counter at 0.
- Macro pins are driven only from registers, never combinationally from requester inputs.
- INIT:
  - Each cycle issue csb0=0, web0=0, wmask0=all-ones, spare_wen0=1, din0=0, addr0=counter.
  - Increment the counter every cycle.
  - After issuing address INIT_DEPTH-1, go to RUN and set init_done=1. Total INIT_DEPTH cycles.
  - Both req_ready are held 0 during INIT.
- RUN arbitration:
  - Grant is combinational from the two valids and the pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester the pointer selects is granted, and the pointer flips to the other port after the grant.
  - pX_req_ready = (state==RUN) and granted X. A handshake is valid && ready.
  - One command is accepted per cycle, reads and writes mixed, with no bubbles.
- Command register: an accepted request is registered onto the sram_* pins at the accepting posedge. Idle cycles drive csb0=1 and web0=1.
- Read pipeline:
  - A 2-stage token (valid, port id) runs alongside each read.
  - Read accepted at edge k; macro captures the command at edge k+1.
  - sram_dout0 is sampled at edge k+2, and rsp_valid/rsp_rdata to the owning port are asserted in the cycle after edge k+2.
  - Read latency is therefore 2 cycles.
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes:
  - Writes return no response.
  - Write to A followed by read of A on the next accepted cycle returns the new data; no stall.
  - A write with wmask=0 is issued as-is and changes no bytes.
- Simultaneous events: a response strobe and a new accept in the same cycle are independent. The two ports' responses never collide, since one read is issued per cycle.
- Reset mid-operation: any state returns to INIT the following cycle. Pending responses are dropped, not delivered, and the clear sequence restarts at address 0.

Optional Feature:
- Macro: SRAM_ARB_PARITY_EN.
- With the macro defined:
  - Bit 32 stores even parity of bits 31:0.
  - Full writes (wmask all-ones) drive din0[32]=^wdata with spare_wen0=1.
  - Partial writes run a read-modify-write: RMW_RD issues the read, RMW_WAIT waits 2 cycles, RMW_WR writes the merged full word with parity.
  - Both req_ready are 0 from the RMW accept until RMW_WR is issued.
  - Reads compare parity; a mismatch gives rsp_perr=1 with rsp_valid.
  - INIT writes parity 0, which is correct for zero data.
- Without the macro:
  - sram_spare_wen0=0 and din0[32]=0 in RUN.
  - Partial writes go directly to the macro with no RMW.
  - rsp_perr is tied 0.

Test Plan:
- Reset with INIT_DEPTH=512:
  - init_done rises exactly 512 cycles after rst0 falls.
  - A read of addr 0x1FF then returns 0x00000000 with perr=0.
- Both ports hold valid for 4 cycles -> grants alternate p0, p1, p0, p1. p1 alone -> granted every cycle.
- p0 writes 0xDEADBEEF to 0x005, then p1 reads 0x005 the next cycle -> p1_rsp_valid 2 cycles later, data 0xDEADBEEF, p0_rsp_valid stays 0.
- Word is 0x11223344; write 0xAABBCCDD with wmask=4'b0101 -> readback 0x11BB33DD.
- With SRAM_ARB_PARITY_EN:
  - The partial write above takes the RMW path and stalls ready for its duration.
  - Bench flips sram_dout0[0] on one read -> rsp_perr=1 on that response only.
- rst0 pulsed mid-INIT at counter 100, and separately with a read in flight -> counter restarts at 0 and no rsp_valid is emitted for the dropped read.
